// File: rtl/note_output_arbiter_if.sv
// -----------------------------------------------------------------------------
// note_output_arbiter_if
// Bundles the three note-source requests and the tone-generator outputs of
// note_output_arbiter.
//   req_valid[2:0] : per-source request (bit0 free-play, bit1 learning,
//                    bit2 auto-play)
//   req_note0..2   : note requested by each source (0 = no note)
//   tone_note      : note driven to the tone generator (0 = silence)
//   tone_en        : tone generator enable
//   grant[2:0]     : one-hot owner of the tone generator, 0 when none
//   note_start     : one-cycle pulse when a note begins
//   busy           : arbiter is sounding a note or in the silent gap
// Modports: master = request side (mode blocks), slave = the arbiter.
// -----------------------------------------------------------------------------
interface note_output_arbiter_if;
  logic [2:0] req_valid;
  logic [3:0] req_note0;
  logic [3:0] req_note1;
  logic [3:0] req_note2;
  logic [3:0] tone_note;
  logic       tone_en;
  logic [2:0] grant;
  logic       note_start;
  logic       busy;

  modport master (
    output req_valid, req_note0, req_note1, req_note2,
    input  tone_note, tone_en, grant, note_start, busy
  );

  modport slave (
    input  req_valid, req_note0, req_note1, req_note2,
    output tone_note, tone_en, grant, note_start, busy
  );
endinterface

// File: rtl/note_output_arbiter.sv
// -----------------------------------------------------------------------------
// note_output_arbiter
// Shares the buzzer tone generator among free-play, learning and auto-play
// note sources. Fixed priority (free-play highest), a minimum audible hold per
// note, and a silent gap after every note so repeated notes re-articulate.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : note_output_arbiter_if.slave (requests in, tone outputs out)
// Parameters:
//   MIN_HOLD_CYCLES : minimum cycles a granted note sounds (>=1)
//   GAP_CYCLES      : silent cycles after every note (>=1)
//   CNT_W           : hold/gap counter width
// Configuration macro:
//   NOTE_ARB_PREEMPT_EN : when defined, a strictly higher-priority eligible
//                         source releases the current owner's note.
// All outputs are registered.
// -----------------------------------------------------------------------------
module note_output_arbiter #(
  parameter int MIN_HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES      = 2500000,
  parameter int CNT_W           = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  note_output_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MIN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic             r_release_pend, w_release_pend_nxt;
  logic [3:0]       r_tone_note, w_tone_note_nxt;
  logic [2:0]       r_grant, w_grant_nxt;
  logic             r_note_start, w_note_start_nxt;
  logic             r_tone_en;
  logic             r_busy;

  logic [2:0]       w_elig;
  logic [2:0]       w_win_grant;
  logic [3:0]       w_win_note;
  logic [3:0]       w_owner_note;
  logic             w_owner_elig;
  logic             w_preempt;
  logic             w_release;
  logic             w_hold_done;
  logic             w_gap_done;

  // A request carrying note 0 is the same as no request.
  assign w_elig[0] = bus.req_valid[0] & (bus.req_note0 != 4'd0);
  assign w_elig[1] = bus.req_valid[1] & (bus.req_note1 != 4'd0);
  assign w_elig[2] = bus.req_valid[2] & (bus.req_note2 != 4'd0);

  // Fixed-priority pick: lowest index wins.
  always_comb begin
    w_win_grant = 3'b000;
    w_win_note  = 4'd0;
    if (w_elig[0]) begin
      w_win_grant = 3'b001;
      w_win_note  = bus.req_note0;
    end else if (w_elig[1]) begin
      w_win_grant = 3'b010;
      w_win_note  = bus.req_note1;
    end else if (w_elig[2]) begin
      w_win_grant = 3'b100;
      w_win_note  = bus.req_note2;
    end else begin
      w_win_grant = 3'b000;
      w_win_note  = 4'd0;
    end
  end

  // Current input note of the owning source.
  always_comb begin
    w_owner_note = 4'd0;
    case (r_grant)
      3'b001:  w_owner_note = bus.req_note0;
      3'b010:  w_owner_note = bus.req_note1;
      3'b100:  w_owner_note = bus.req_note2;
      default: w_owner_note = 4'd0;
    endcase
  end

  assign w_owner_elig = |(w_elig & r_grant);

`ifdef NOTE_ARB_PREEMPT_EN
  // grant - 1 is a mask of every source with higher priority than the owner.
  assign w_preempt = (r_grant != 3'b000) & (|(w_elig & (r_grant - 3'b001)));
`else
  assign w_preempt = 1'b0;
`endif

  assign w_release   = ~w_owner_elig | (w_owner_note != r_tone_note) | w_preempt;
  assign w_hold_done = (r_hold_cnt == C_HOLD_LAST);
  assign w_gap_done  = (r_gap_cnt == C_GAP_LAST);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt        = r_state;
    w_hold_cnt_nxt     = r_hold_cnt;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_release_pend_nxt = r_release_pend;
    w_tone_note_nxt    = r_tone_note;
    w_grant_nxt        = r_grant;
    w_note_start_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_grant != 3'b000) begin
          w_state_nxt        = ST_PLAY;
          w_grant_nxt        = w_win_grant;
          w_tone_note_nxt    = w_win_note;
          w_note_start_nxt   = 1'b1;
          w_hold_cnt_nxt     = C_CNT_ZERO;
          w_release_pend_nxt = 1'b0;
        end else begin
          w_grant_nxt     = 3'b000;
          w_tone_note_nxt = 4'd0;
        end
      end
      ST_PLAY: begin
        // A release seen before the hold completes is kept until it does.
        if (w_hold_done && (w_release || r_release_pend)) begin
          w_state_nxt        = ST_GAP;
          w_grant_nxt        = 3'b000;
          w_tone_note_nxt    = 4'd0;
          w_gap_cnt_nxt      = C_CNT_ZERO;
          w_release_pend_nxt = 1'b0;
        end else begin
          if (!w_hold_done) begin
            w_hold_cnt_nxt = r_hold_cnt + C_CNT_ONE;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt;
          end
          if (w_release) begin
            w_release_pend_nxt = 1'b1;
          end else begin
            w_release_pend_nxt = r_release_pend;
          end
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_state_nxt   = ST_IDLE;
          w_gap_cnt_nxt = C_CNT_ZERO;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt        = ST_IDLE;
        w_hold_cnt_nxt     = C_CNT_ZERO;
        w_gap_cnt_nxt      = C_CNT_ZERO;
        w_release_pend_nxt = 1'b0;
        w_tone_note_nxt    = 4'd0;
        w_grant_nxt        = 3'b000;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_hold_cnt     <= C_CNT_ZERO;
      r_gap_cnt      <= C_CNT_ZERO;
      r_release_pend <= 1'b0;
      r_tone_note    <= 4'd0;
      r_grant        <= 3'b000;
      r_note_start   <= 1'b0;
      r_tone_en      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_release_pend <= w_release_pend_nxt;
      r_tone_note    <= w_tone_note_nxt;
      r_grant        <= w_grant_nxt;
      r_note_start   <= w_note_start_nxt;
      r_tone_en      <= (w_state_nxt == ST_PLAY);
      r_busy         <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.tone_note  = r_tone_note;
  assign bus.tone_en    = r_tone_en;
  assign bus.grant      = r_grant;
  assign bus.note_start = r_note_start;
  assign bus.busy       = r_busy;

endmodule
